// File: rtl/alias_slice_arb.sv
// alias_slice_arb: round-robin arbiter granting HOLD-cycle writes of 16-bit slices into one shared 32-bit word
module alias_slice_arb #(
  parameter int NREQ = 3,
  parameter int HOLD = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      sel_hi,
  input  logic [16*NREQ-1:0]   wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [31:0]          word_q,
  output logic                 busy,
  output logic                 done,
  output logic                 abort
);
  localparam int W = (NREQ > 2) ? 2 : 1;
  typedef enum logic {IDLE, GRANT} state_t;
  state_t         state;
  logic [W-1:0]   rr_ptr, win, pick, idx, nxt;
  logic [3:0]     cnt;
  // first requesting index at or above rr_ptr, wrapping; scanned high-to-low so the nearest wins
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = W'((int'(rr_ptr) + k) % NREQ);
      if (req[idx]) pick = idx;
    end
  end
  assign nxt  = (win == W'(NREQ - 1)) ? '0 : win + 1'b1;
  assign busy = (state == GRANT);
  // arbitration, hold countdown, commit or abort of the current transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      win    <= '0;
      cnt    <= '0;
      gnt    <= '0;
      word_q <= '0;
      done   <= 1'b0;
      abort  <= 1'b0;
    end else begin
      done  <= 1'b0;
      abort <= 1'b0;
      if (state == IDLE) begin
        if (|req) begin
          state <= GRANT;
          win   <= pick;
          gnt   <= NREQ'(1) << pick;
          cnt   <= 4'(HOLD - 1);
        end
      end else if (!req[win]) begin
        abort  <= 1'b1;
        gnt    <= '0;
        rr_ptr <= nxt;
        state  <= IDLE;
      end else if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end else begin
        done   <= 1'b1;
        gnt    <= '0;
        rr_ptr <= nxt;
        state  <= IDLE;
        if (sel_hi[win]) word_q[31:16] <= wdata[16*win +: 16];
        else word_q[15:0] <= wdata[16*win +: 16];
      end
    end
  end
endmodule

// File: tb/tb_alias_slice_arb.sv
// tb_alias_slice_arb: directed scenarios checked against a transaction-level model every cycle
module tb_alias_slice_arb;
  localparam int NREQ = 3;
  localparam int HOLD = 2;
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   sel_hi = '0;
  logic [16*NREQ-1:0] wdata = '0;
  logic [NREQ-1:0]   gnt;
  logic [31:0]       word_q;
  logic              busy, done, abort;
  int n_checks = 0;
  int n_fail = 0;

  alias_slice_arb #(.NREQ(NREQ), .HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .sel_hi(sel_hi), .wdata(wdata),
    .gnt(gnt), .word_q(word_q), .busy(busy), .done(done), .abort(abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // model: owner of the current transaction (-1 when idle) and how many grant cycles it has had
  int          m_owner = -1;
  int          m_age = 0;
  int          m_ptr = 0;
  logic [31:0] m_word = '0;
  logic        m_done = 1'b0;
  logic        m_abort = 1'b0;
  logic        started = 1'b0;

  always @(posedge clk) begin
    started <= 1'b1;
    m_done  <= 1'b0;
    m_abort <= 1'b0;
    if (rst) begin
      m_owner <= -1;
      m_ptr   <= 0;
      m_word  <= '0;
    end else if (m_owner < 0) begin
      for (int k = NREQ - 1; k >= 0; k--)
        if (req[(m_ptr + k) % NREQ]) begin
          m_owner <= (m_ptr + k) % NREQ;
          m_age   <= 1;
        end
    end else if (!req[m_owner]) begin
      m_abort <= 1'b1;
      m_ptr   <= (m_owner + 1) % NREQ;
      m_owner <= -1;
    end else if (m_age == HOLD) begin
      m_done  <= 1'b1;
      m_ptr   <= (m_owner + 1) % NREQ;
      m_owner <= -1;
      if (sel_hi[m_owner]) m_word[31:16] <= wdata[16*m_owner +: 16];
      else m_word[15:0] <= wdata[16*m_owner +: 16];
    end else begin
      m_age <= m_age + 1;
    end
  end

  // every-cycle comparison against the model plus the structural invariants
  always @(negedge clk) begin
    if (started) begin
      chk("gnt", 32'(gnt), (m_owner < 0) ? 32'h0 : (32'h1 << m_owner));
      chk("word_q", word_q, m_word);
      chk("busy", 32'(busy), 32'(m_owner >= 0));
      chk("done", 32'(done), 32'(m_done));
      chk("abort", 32'(abort), 32'(m_abort));
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'h1);
      chk("done_abort_excl", 32'(done && abort), 32'h0);
      chk("busy_eq_orgnt", 32'(busy), 32'(|gnt));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_until_done(input string name, output int ngnt);
    bit seen;
    seen = 1'b0;
    ngnt = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (gnt != '0) ngnt++;
      if (done) seen = 1'b1;
    end
    chk(name, 32'(seen), 32'h1);
  endtask

  initial begin
    int ng, ndone, norder;
    logic [NREQ-1:0] order [4];
    logic [NREQ-1:0] prev;
    cyc(2);
    chk("reset_word", word_q, 32'h0);
    chk("reset_gnt", 32'(gnt), 32'h0);
    rst = 1'b0;
    // single write of BEEF into the high half
    req = 3'b001; sel_hi = 3'b001; wdata = 48'h0000_0000_BEEF;
    run_until_done("s1_done_seen", ng);
    chk("s1_gnt_cycles", 32'(ng), 32'd2);
    chk("s1_word", word_q, 32'hBEEF_0000);
    req = '0;
    cyc(2);
    // round robin with all requesting from reset
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    req = 3'b111; sel_hi = '0; wdata = 48'h3333_2222_1111;
    ndone = 0; norder = 0; prev = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
      if (gnt != '0 && gnt != prev && norder < 4) begin
        order[norder] = gnt;
        norder++;
      end
      prev = gnt;
    end
    chk("rr_done_count", 32'(ndone), 32'd4);
    chk("rr_order0", 32'(order[0]), 32'b001);
    chk("rr_order1", 32'(order[1]), 32'b010);
    chk("rr_order2", 32'(order[2]), 32'b100);
    chk("rr_order3", 32'(order[3]), 32'b001);
    req = '0;
    cyc(2);
    // half preservation
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    req = 3'b010; sel_hi = 3'b000; wdata = 48'h0000_1234_0000;
    run_until_done("hp_done1", ng);
    req = 3'b100; sel_hi = 3'b100; wdata = 48'hABCD_0000_0000;
    run_until_done("hp_done2", ng);
    chk("hp_word", word_q, 32'hABCD_1234);
    req = '0;
    cyc(1);
    // abort of requester 0, next grant to requester 1
    req = 3'b011; sel_hi = 3'b000; wdata = 48'h0000_0000_FFFF;
    cyc(1);
    chk("ab_first_gnt", 32'(gnt), 32'b001);
    req = 3'b010;
    cyc(1);
    chk("ab_pulse", 32'(abort), 32'h1);
    chk("ab_word_kept", word_q, 32'hABCD_1234);
    cyc(1);
    chk("ab_next_gnt", 32'(gnt), 32'b010);
    req = '0;
    cyc(3);
    // reset on the commit edge
    req = 3'b001; sel_hi = 3'b001; wdata = 48'h0000_0000_5555;
    cyc(2);
    chk("rm_gnt_before", 32'(gnt), 32'b001);
    rst = 1'b1;
    cyc(1);
    chk("rm_word", word_q, 32'h0);
    chk("rm_gnt", 32'(gnt), 32'h0);
    chk("rm_no_done", 32'(done), 32'h0);
    rst = 1'b0;
    req = 3'b100;
    cyc(1);
    chk("rm_next_gnt", 32'(gnt), 32'b100);
    chk("rm_no_done2", 32'(done), 32'h0);
    req = '0;
    cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
